// File: rtl/pcs_tx_pkg.sv
// Shared constants for the PCS transmit code-group sequencer:
// ordered-set select / code-group values and one-hot state encodings.
package pcs_tx_pkg;

  localparam logic [7:0] CG_I      = 8'hBC;  // K28.5, first code group of /I/
  localparam logic [7:0] CG_S      = 8'hFB;  // K27.7 start of packet
  localparam logic [7:0] CG_R      = 8'hF7;  // K23.7 carrier extend / alignment fill
  localparam logic [7:0] CG_T      = 8'hFD;  // K29.7 end of packet
  localparam logic [7:0] CG_D      = 8'hFF;  // select value meaning "send txd"
  localparam logic [7:0] CG_ERR    = 8'hFE;  // K30.7 error propagation
  localparam logic [7:0] CG_D16_2  = 8'h50;  // D16.2, second code group of /I/

  typedef enum logic [3:0] {
    ST_OFF    = 4'b0001,
    ST_LOAD   = 4'b0010,
    ST_IDLE_K = 4'b0100,
    ST_IDLE_D = 4'b1000
  } state_t;

endpackage

// File: rtl/pcs_tx_pkt_counter.sv
// Wrapping packet counter with enable and synchronous active-low clear.
module pcs_tx_pkt_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Clear wins over enable; the count wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pcs_transmit_code_group.sv
// Transmit code-group sequencer: turns ordered-set selections and GMII
// octets into one unencoded code group per clock, owns even/odd alignment
// and paces the ordered-set FSM through tx_oset_indicate.
//
// state   | meaning
// --------+-------------------------------------------------------------
// OFF     | PCS disabled; outputs zero, request first ordered set
// LOAD    | tx_oset_indicate high; sample tx_o_set/txd this edge
// IDLE_K  | misaligned /I/: R fill shown, K28.5 goes out next
// IDLE_D  | K28.5 shown, D16.2 goes out next, then back to LOAD
module pcs_transmit_code_group
  import pcs_tx_pkg::*;
#(
  parameter int         CNT_W  = 8,
  parameter logic [7:0] IDLE_D = CG_D16_2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             power_on,
  input  logic [7:0]       tx_o_set,
  input  logic [7:0]       txd,
  output logic [7:0]       tx_code_group,
  output logic             tx_k,
  output logic             tx_even,
  output logic             tx_oset_indicate,
  output logic [CNT_W-1:0] tx_pkt_count
);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cg_nxt;
  logic       k_nxt;
  logic       even_nxt;
  logic       ind_nxt;
  logic       cnt_en;

  // State and registered outputs; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= ST_OFF;
      tx_code_group    <= '0;
      tx_k             <= 1'b0;
      tx_even          <= 1'b0;
      tx_oset_indicate <= 1'b0;
    end else begin
      state            <= state_nxt;
      tx_code_group    <= cg_nxt;
      tx_k             <= k_nxt;
      tx_even          <= even_nxt;
      tx_oset_indicate <= ind_nxt;
    end
  end

  // Next state; /I/ alignment is decided from the parity the K28.5 would get.
  always_comb begin
    state_nxt = ST_OFF;
    if (power_on) begin
      case (state)
        ST_OFF:    state_nxt = ST_LOAD;
        ST_LOAD: begin
          if (tx_o_set == CG_I) begin
            state_nxt = (!tx_even) ? ST_IDLE_D : ST_IDLE_K;
          end else begin
            state_nxt = ST_LOAD;
          end
        end
        ST_IDLE_K: state_nxt = ST_IDLE_D;
        ST_IDLE_D: state_nxt = ST_LOAD;
        default:   state_nxt = ST_OFF;
      endcase
    end
  end

  // Next output values; power_on low or an illegal state zeroes everything.
  always_comb begin
    cg_nxt   = '0;
    k_nxt    = 1'b0;
    even_nxt = 1'b0;
    ind_nxt  = 1'b0;
    if (power_on) begin
      case (state)
        ST_OFF: begin
          ind_nxt = 1'b1;
        end
        ST_LOAD: begin
          even_nxt = ~tx_even;
          case (tx_o_set)
            CG_S, CG_T, CG_R: begin
              cg_nxt  = tx_o_set;
              k_nxt   = 1'b1;
              ind_nxt = 1'b1;
            end
            CG_D: begin
              cg_nxt  = txd;
              ind_nxt = 1'b1;
            end
            CG_I: begin
              // An odd slot gets an R fill so K28.5 always lands even.
              cg_nxt = (!tx_even) ? CG_I : CG_R;
              k_nxt  = 1'b1;
            end
            default: begin
              cg_nxt  = CG_ERR;
              k_nxt   = 1'b1;
              ind_nxt = 1'b1;
            end
          endcase
        end
        ST_IDLE_K: begin
          even_nxt = ~tx_even;
          cg_nxt   = CG_I;
          k_nxt    = 1'b1;
        end
        ST_IDLE_D: begin
          even_nxt = ~tx_even;
          cg_nxt   = IDLE_D;
          ind_nxt  = 1'b1;
        end
        default: begin
          cg_nxt = '0;
        end
      endcase
    end
  end

  // Count /S/ only when it is actually consumed at a load edge.
  always_comb begin
    cnt_en = power_on && (state == ST_LOAD) && (tx_o_set == CG_S);
  end

  pcs_tx_pkt_counter #(
    .CNT_W (CNT_W)
  ) u_pkt_counter (
    .clk   (clk),
    .clear (rst),
    .en    (cnt_en),
    .count (tx_pkt_count)
  );

endmodule

// File: tb/tb_pcs_transmit_code_group.sv
// Bench for pcs_transmit_code_group: a vector table of per-edge inputs and
// expected outputs fed through a scoreboard queue, followed by a random
// run checking K28.5 parity and bounded recovery after power_on drops.
module tb_pcs_transmit_code_group;

  logic       clk;
  logic       rst;
  logic       power_on;
  logic [7:0] tx_o_set;
  logic [7:0] txd;

  logic [7:0] cg8, cg2;
  logic       k8, k2, ev8, ev2, ind8, ind2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  pcs_transmit_code_group #(.CNT_W(8), .IDLE_D(8'h50)) dut (
    .clk              (clk),
    .rst              (rst),
    .power_on         (power_on),
    .tx_o_set         (tx_o_set),
    .txd              (txd),
    .tx_code_group    (cg8),
    .tx_k             (k8),
    .tx_even          (ev8),
    .tx_oset_indicate (ind8),
    .tx_pkt_count     (cnt8)
  );

  pcs_transmit_code_group #(.CNT_W(2), .IDLE_D(8'h50)) dut_small (
    .clk              (clk),
    .rst              (rst),
    .power_on         (power_on),
    .tx_o_set         (tx_o_set),
    .txd              (txd),
    .tx_code_group    (cg2),
    .tx_k             (k2),
    .tx_even          (ev2),
    .tx_oset_indicate (ind2),
    .tx_pkt_count     (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cg;
    logic       k;
    logic       ev;
    logic       ind;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic       r;
    logic       p;
    logic [7:0] oset;
    logic [7:0] d;
    exp_t       exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  function automatic void add(input logic r, input logic p, input logic [7:0] oset,
                              input logic [7:0] d, input logic [7:0] cg, input logic k,
                              input logic ev, input logic ind, input logic [7:0] cnt);
    vec_t v;
    v.r = r; v.p = p; v.oset = oset; v.d = d;
    v.exp.cg = cg; v.exp.k = k; v.exp.ev = ev; v.exp.ind = ind; v.exp.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic compare_row(input int row, input exp_t e);
    exp_t got8;
    logic [7:0] cg_small_exp;
    got8 = {cg8, k8, ev8, ind8, cnt8};
    checks++;
    if (got8 !== e) begin
      errors++;
      $display("FAIL row%0d_main: got cg=%h k=%b even=%b ind=%b cnt=%0d, want cg=%h k=%b even=%b ind=%b cnt=%0d",
               row, cg8, k8, ev8, ind8, cnt8, e.cg, e.k, e.ev, e.ind, e.cnt);
    end
    cg_small_exp = e.cnt;
    checks++;
    if ({cg2, k2, ev2, ind2, cnt2} !== {e.cg, e.k, e.ev, e.ind, cg_small_exp[1:0]}) begin
      errors++;
      $display("FAIL row%0d_cnt2: got cg=%h k=%b even=%b ind=%b cnt=%0d, want cg=%h k=%b even=%b ind=%b cnt=%0d",
               row, cg2, k2, ev2, ind2, cnt2, e.cg, e.k, e.ev, e.ind, cg_small_exp[1:0]);
    end
  endtask

  initial begin
    exp_t e;
    logic [7:0] osets [6];
    int  wait_cnt;

    rst = 1'b0; power_on = 1'b0; tx_o_set = 8'hBC; txd = 8'h00;

    //   rst pwr  oset   txd    cg     k  ev ind cnt
    add(0, 0, 8'hBC, 8'h00, 8'h00, 0, 0, 0, 0);  // reset
    add(0, 1, 8'hBC, 8'h00, 8'h00, 0, 0, 0, 0);  // reset dominates power_on
    add(1, 1, 8'hBC, 8'h00, 8'h00, 0, 0, 1, 0);  // OFF -> LOAD
    add(1, 1, 8'hBC, 8'h00, 8'hBC, 1, 1, 0, 0);  // aligned /I/
    add(1, 1, 8'hBC, 8'h00, 8'h50, 0, 0, 1, 0);
    add(1, 1, 8'hFB, 8'h00, 8'hFB, 1, 1, 1, 1);  // S
    add(1, 1, 8'hFF, 8'h00, 8'h00, 0, 0, 1, 1);
    add(1, 1, 8'hFF, 8'h01, 8'h01, 0, 1, 1, 1);
    add(1, 1, 8'hFF, 8'h02, 8'h02, 0, 0, 1, 1);
    add(1, 1, 8'hFD, 8'h00, 8'hFD, 1, 1, 1, 1);  // T
    add(1, 1, 8'hF7, 8'h00, 8'hF7, 1, 0, 1, 1);  // R
    add(1, 1, 8'hBC, 8'h00, 8'hBC, 1, 1, 0, 1);  // /I/ lands even
    add(1, 1, 8'hBC, 8'h00, 8'h50, 0, 0, 1, 1);
    add(1, 1, 8'hFB, 8'h00, 8'hFB, 1, 1, 1, 2);  // odd-length packet
    add(1, 1, 8'hFF, 8'hAA, 8'hAA, 0, 0, 1, 2);
    add(1, 1, 8'hFD, 8'h00, 8'hFD, 1, 1, 1, 2);
    add(1, 1, 8'hBC, 8'h00, 8'hF7, 1, 0, 0, 2);  // misaligned /I/: R fill
    add(1, 1, 8'hFF, 8'h55, 8'hBC, 1, 1, 0, 2);  // inputs ignored, not a load edge
    add(1, 1, 8'hFB, 8'h00, 8'h50, 0, 0, 1, 2);  // S not consumed, count holds
    add(1, 1, 8'h3C, 8'h00, 8'hFE, 1, 1, 1, 2);  // illegal select -> K30.7
    add(1, 1, 8'hBC, 8'h00, 8'hF7, 1, 0, 0, 2);
    add(1, 1, 8'hBC, 8'h00, 8'hBC, 1, 1, 0, 2);  // K28.5 shown
    add(1, 0, 8'hBC, 8'h00, 8'h00, 0, 0, 0, 2);  // power drop aborts /I/
    add(1, 1, 8'hBC, 8'h00, 8'h00, 0, 0, 1, 2);  // restart
    add(1, 1, 8'hBC, 8'h00, 8'hBC, 1, 1, 0, 2);
    add(1, 1, 8'hFB, 8'h00, 8'h50, 0, 0, 1, 2);
    add(1, 1, 8'hFB, 8'h00, 8'hFB, 1, 1, 1, 3);
    add(1, 1, 8'hFB, 8'h00, 8'hFB, 1, 0, 1, 4);  // small counter wraps to 0
    add(1, 1, 8'hFB, 8'h00, 8'hFB, 1, 1, 1, 5);
    add(1, 1, 8'hFB, 8'h00, 8'hFB, 1, 0, 1, 6);
    add(1, 1, 8'hFF, 8'h5A, 8'h5A, 0, 1, 1, 6);
    add(0, 1, 8'hFF, 8'h5B, 8'h00, 0, 0, 0, 0);  // reset mid-packet
    add(0, 1, 8'hFB, 8'h5C, 8'h00, 0, 0, 0, 0);  // held in reset
    add(1, 1, 8'hFB, 8'h00, 8'h00, 0, 0, 1, 0);
    add(1, 1, 8'hFB, 8'h00, 8'hFB, 1, 1, 1, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].r; power_on = vecs[i].p;
      tx_o_set = vecs[i].oset; txd = vecs[i].d;
      sb_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      compare_row(i, e);
    end

    // Random traffic: K28.5 must always sit on an even slot, and after a
    // power drop the block must ask for an ordered set within a few cycles.
    osets[0] = 8'hBC; osets[1] = 8'hFB; osets[2] = 8'hF7;
    osets[3] = 8'hFD; osets[4] = 8'hFF; osets[5] = 8'h3C;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst = 1'b1;
      power_on = ($urandom_range(0, 29) != 0);
      tx_o_set = osets[$urandom_range(0, 5)];
      txd = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      if (k8 && cg8 == 8'hBC) begin
        checks++;
        if (ev8 !== 1'b1) begin
          errors++;
          $display("FAIL k285_parity: got even=%b, want 1 (cycle %0d)", ev8, n);
        end
      end
      if (!power_on) begin
        @(negedge clk);
        power_on = 1'b1;
        wait_cnt = 0;
        while (ind8 !== 1'b1 && wait_cnt < 4) begin
          @(posedge clk);
          #1;
          wait_cnt++;
        end
        checks++;
        if (ind8 !== 1'b1 || ev8 !== 1'b0) begin
          errors++;
          $display("FAIL restart_indicate: got ind=%b even=%b after %0d cycles, want ind=1 even=0",
                   ind8, ev8, wait_cnt);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
